mem_access_unit: RTL
====================

# mem_access_unit

Load/store and fetch memory interface for the mARC datapath. Sits downstream of the file register's A/B buses, taking the effective address from busA and store data from busB. Runs a request/acknowledge transaction with external memory and returns read data for the register-file write-data mux, to be written on the following negative clock edge. Handles byte/word sizing, alignment checking and a bounded wait for memory acknowledge.

## Interface
Parameters:
- TIMEOUT, 16: maximum cycles spent in REQ waiting for mem_ack before aborting; legal range 2..255.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a transaction; sampled only in IDLE.
- we  in  1  1 = store, 0 = load/fetch.
- size  in  1  1 = 16-bit word, 0 = byte.
- addr  in  16  byte address (from busA).
- wdata  in  16  store data (from busB).
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse at transaction end (success or error).
- error  out  1  one-cycle pulse, coincident with done, on misalign or timeout.
- rdata  out  16  load result; held until the next successful load completes.
- mem_req  out  1  memory request; held high throughout REQ.
- mem_we  out  1  memory write enable.
- mem_addr  out  15  word address = addr[15:1].
- mem_be  out  2  byte enables; bit0 = bits[7:0], bit1 = bits[15:8].
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  memory read data; valid when mem_ack is high.
- mem_ack  in  1  memory acknowledge, single cycle.

## Operation
- States: IDLE, REQ, DONE, ERR.
- IDLE, start=1:
  - latch we, size, addr, wdata.
  - word with addr[0]=1 goes to ERR; otherwise goes to REQ.
- REQ:
  - mem_req=1; mem_we, mem_addr, mem_be, mem_wdata are registered and stable.
  - Word access: mem_be=2'b11, mem_wdata=wdata.
  - Byte access: mem_be=2'b01 if addr[0]=0, else 2'b10; mem_wdata={wdata[7:0],wdata[7:0]}.
  - mem_ack=1 at a rising edge: go to DONE; a load captures rdata.
  - No ack by the TIMEOUT-th REQ cycle: go to ERR; rdata is unchanged.
- Load data formatting:
  - Word: rdata = mem_rdata.
  - Byte, addr[0]=0: rdata = {8'h00, mem_rdata[7:0]}.
  - Byte, addr[0]=1: rdata = {8'h00, mem_rdata[15:8]}.
- DONE: done=1 for one cycle, then IDLE.
- ERR: done=1 and error=1 for one cycle, then IDLE. No memory request is issued for a misaligned access.
- start is ignored while busy=1, including the DONE and ERR cycles.
- mem_ack outside REQ is ignored.
- Stores never modify rdata.

## Timing
- Reset (reset=0, asynchronous) forces:
  - state IDLE; busy, done, error, mem_req, mem_we all 0.
  - mem_be=0, mem_addr=0, mem_wdata=0, rdata=16'h0000, wait counter 0.
- Reset mid-REQ drops mem_req immediately, without waiting for a clock edge. A later mem_ack is ignored.
- Minimum latency, with ack in the first REQ cycle:
  - start sampled at edge 0.
  - mem_req high in cycle 1.
  - ack sampled at edge 2.
  - done and new rdata valid in cycle 2.
- rdata and done are stable across the negative edge of the done cycle, so the file register captures them in that cycle.
- Misaligned access: start at edge 0, ERR cycle 1 (done=error=1), IDLE at edge 2.
- Timeout: mem_req is high for exactly TIMEOUT cycles, then the ERR cycle follows.
- The wait counter is 8 bits, cleared on REQ entry, and never wraps while in REQ.
- Back-to-back transactions: start asserted in the DONE cycle is ignored. The earliest next start is sampled at the first IDLE edge.

## Structure
- Package marc_mem_pkg:
  - state enum (IDLE, REQ, DONE, ERR).
  - size encodings SIZE_BYTE=0, SIZE_WORD=1.
  - mem_be constants BE_LO=2'b01, BE_HI=2'b10, BE_WORD=2'b11.
- Sub-module mem_lane_steer: combinational steering.
  - Store side: generates mem_be and mem_wdata from size, addr[0] and wdata.
  - Load side: selects and zero-extends the read lane.
- FSM, wait counter and output registers stay in mem_access_unit.

## Test plan
- Word load: addr=16'h0124, size=1, we=0; ack in first REQ cycle with mem_rdata=16'hBEEF -> mem_addr=15'h0092, mem_be=2'b11; done in cycle 2 with rdata=16'hBEEF; error=0.
- Byte load from the high lane: addr=16'h0125, size=0, mem_rdata=16'hA55A -> mem_be=2'b10, rdata=16'h00A5. Repeat with addr=16'h0124 -> mem_be=2'b01, rdata=16'h005A.
- Byte store: addr=16'h0011, wdata=16'h1234, we=1 -> mem_we=1, mem_be=2'b10, mem_wdata=16'h3434; rdata unchanged after done.
- Misaligned word: addr=16'h0003, size=1 -> mem_req never asserted; done=error=1 in cycle 1; then IDLE.
- Timeout with TIMEOUT=4 and no ack -> mem_req high for exactly 4 cycles; then done=error=1; rdata retains its prior value. A late ack in IDLE has no effect.
- Reset pulse mid-REQ, plus start held high through DONE -> mem_req drops asynchronously and all outputs return to reset values. Start during DONE does not begin a second transaction.

Source files
------------

// File: rtl/marc_mem_pkg.sv
// marc_mem_pkg: shared states, size encodings and byte-enable constants for the memory access unit
package marc_mem_pkg;
  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;
  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;
  localparam logic [1:0] BE_LO = 2'b01;
  localparam logic [1:0] BE_HI = 2'b10;
  localparam logic [1:0] BE_WORD = 2'b11;
endpackage

// File: rtl/mem_lane_steer.sv
// mem_lane_steer: byte-lane steering for stores and lane select/zero-extend for loads
module mem_lane_steer (
  input  logic        st_size,
  input  logic        st_a0,
  input  logic [15:0] wdata,
  output logic [1:0]  be,
  output logic [15:0] st_data,
  input  logic        ld_size,
  input  logic        ld_a0,
  input  logic [15:0] rd_in,
  output logic [15:0] rd_out
);
  import marc_mem_pkg::*;
  // store byte replicates into both lanes so the enable alone picks the target byte
  always_comb begin
    be = (st_size == SIZE_WORD) ? BE_WORD : (st_a0 ? BE_HI : BE_LO);
    st_data = (st_size == SIZE_WORD) ? wdata : {wdata[7:0], wdata[7:0]};
    rd_out = (ld_size == SIZE_WORD) ? rd_in : {8'h00, ld_a0 ? rd_in[15:8] : rd_in[7:0]};
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: request/acknowledge load/store engine with alignment check and bounded ack wait
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        we,
  input  logic        size,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [14:0] mem_addr,
  output logic [1:0]  mem_be,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack
);
  import marc_mem_pkg::*;
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        size_q, size_d, a0_q, a0_d, mem_we_q, mem_we_d;
  logic [14:0] mem_addr_q, mem_addr_d;
  logic [1:0]  mem_be_q, mem_be_d, be_s;
  logic [15:0] mem_wdata_q, mem_wdata_d, rdata_q, rdata_d, wd_s, rd_s;
  mem_lane_steer u_steer (
    .st_size(size), .st_a0(addr[0]), .wdata(wdata), .be(be_s), .st_data(wd_s),
    .ld_size(size_q), .ld_a0(a0_q), .rd_in(mem_rdata), .rd_out(rd_s)
  );
  // next-state: latch the request in IDLE, wait for ack or timeout in REQ, single-cycle DONE/ERR
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    size_d = size_q;
    a0_d = a0_q;
    mem_we_d = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_be_d = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d = rdata_q;
    if (state_q == IDLE && start) begin
      size_d = size;
      a0_d = addr[0];
      mem_we_d = we;
      mem_addr_d = addr[15:1];
      mem_be_d = be_s;
      mem_wdata_d = wd_s;
      cnt_d = 8'd0;
      state_d = (size == SIZE_WORD && addr[0]) ? ERR : REQ;
    end else if (state_q == REQ) begin
      if (mem_ack) begin
        state_d = DONE;
        rdata_d = mem_we_q ? rdata_q : rd_s;
      end else if (cnt_q == LAST) begin
        state_d = ERR;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end else if (state_q != IDLE) begin
      state_d = IDLE;
    end
  end
  // state and output registers; reset clears everything without waiting for a clock
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= 8'd0;
      size_q <= 1'b0;
      a0_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_addr_q <= 15'd0;
      mem_be_q <= 2'b00;
      mem_wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      size_q <= size_d;
      a0_q <= a0_d;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_be_q <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q <= rdata_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = state_q == DONE || state_q == ERR;
  assign error = state_q == ERR;
  assign mem_req = state_q == REQ;
  assign mem_we = mem_req & mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_be = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata = rdata_q;
endmodule
